// File: rtl/irq_gateway_pkg.sv
// ---------------------------------------------------------------------------
// irq_gateway_pkg
//   Shared types and helpers for the interrupt gateway.
//   - irq_state_e : per-source lifecycle (idle / pending / claimed)
//   - IRQ_ID_NONE : claim ID reported when nothing was claimable
//   - lowest_id() : index+1 of the lowest set bit of a vector, 0 if none
// ---------------------------------------------------------------------------
package irq_gateway_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PENDING,
        IRQ_CLAIMED
    } irq_state_e;

    localparam int IRQ_ID_NONE = 0;

    // Scanning from the top down leaves the lowest set bit as the result,
    // which gives fixed priority to source 0.
    function automatic int lowest_id(input logic [31:0] vec);
        int id;
        id = IRQ_ID_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                id = i + 1;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_gateway_src.sv
// ---------------------------------------------------------------------------
// irq_gateway_src
//   One interrupt source: input synchroniser, edge detect, registered
//   trigger, IDLE/PENDING/CLAIMED state machine and the edge_seen bit that
//   remembers one rising edge arriving while the source is claimed.
//   Optional coalesced-edge counter when IRQ_GATEWAY_STATS_EN is defined.
//
// Ports
//   core_clk     in   clock
//   rst_ni       in   asynchronous active-low reset (already synchronised)
//   irq_i        in   raw asynchronous request
//   edge_mode_i  in   1 = rising-edge triggered, 0 = level triggered
//   claim_i      in   this source wins the current claim
//   complete_i   in   a complete addressed to this source
//   lost_clr_i   in   clear lost counter        (IRQ_GATEWAY_STATS_EN only)
//   lost_cnt_o   out  saturating lost counter   (IRQ_GATEWAY_STATS_EN only)
//   pending_o    out  source is PENDING
// ---------------------------------------------------------------------------
module irq_gateway_src
    import irq_gateway_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       core_clk,
    input  logic       rst_ni,
    input  logic       irq_i,
    input  logic       edge_mode_i,
    input  logic       claim_i,
    input  logic       complete_i,
`ifdef IRQ_GATEWAY_STATS_EN
    input  logic       lost_clr_i,
    output logic [7:0] lost_cnt_o,
`endif
    output logic       pending_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   trig_q;
    logic                   trig_d;
    logic                   sync;
    logic                   rise;
    irq_state_e             state_q;
    irq_state_e             state_d;
    logic                   edge_seen_q;
    logic                   edge_seen_d;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign rise   = sync & ~sync_prev_q;
    // The trigger is registered once more after the synchroniser so the
    // state machine acts on a clean single-flop signal.
    assign trig_d = edge_mode_i ? rise : sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge core_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            trig_q      <= 1'b0;
            state_q     <= IRQ_IDLE;
            edge_seen_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_i};
            sync_prev_q <= sync;
            trig_q      <= trig_d;
            state_q     <= state_d;
            edge_seen_q <= edge_seen_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        edge_seen_d = edge_seen_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (trig_q) begin
                    state_d = IRQ_PENDING;
                end
            end
            IRQ_PENDING: begin
                // Further triggers while pending coalesce into this request.
                if (claim_i) begin
                    state_d = IRQ_CLAIMED;
                end
            end
            IRQ_CLAIMED: begin
                if (complete_i) begin
                    // A remembered edge, or one landing on the complete
                    // itself, is served again without passing through IDLE.
                    edge_seen_d = 1'b0;
                    if (edge_mode_i && (edge_seen_q || trig_q)) begin
                        state_d = IRQ_PENDING;
                    end else begin
                        state_d = IRQ_IDLE;
                    end
                end else if (edge_mode_i && trig_q) begin
                    edge_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    assign pending_o = (state_q == IRQ_PENDING);

`ifdef IRQ_GATEWAY_STATS_EN
    logic       lost;
    logic [7:0] lost_cnt_q;

    // An edge is lost when it folds into an already outstanding request.
    assign lost = edge_mode_i && trig_q &&
                  ((state_q == IRQ_PENDING) ||
                   ((state_q == IRQ_CLAIMED) && edge_seen_q));

    always_ff @(posedge core_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            lost_cnt_q <= 8'd0;
        end else if (lost_clr_i) begin
            lost_cnt_q <= 8'd0;
        end else if (lost && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: rtl/irq_gateway.sv
// ---------------------------------------------------------------------------
// irq_gateway
//   Collects NUM_SRC asynchronous interrupt requests, turns each into a
//   pending bit (level or rising-edge) and presents one aggregated interrupt
//   to the core with a claim/complete handshake returning the winning ID.
//   Optional feature macro: IRQ_GATEWAY_STATS_EN (per-source lost-edge
//   counters with a synchronous clear).
//
// Ports
//   core_clk       in   clock, all logic on the rising edge
//   rst_ni         in   asynchronous active-low reset
//   irq_src_i      in   raw requests [NUM_SRC]
//   edge_mode_i    in   per source 1 = rising edge, 0 = level
//   enable_i       in   per-source enable mask
//   irq_o          out  registered OR of pending & enable
//   claim_req_i    in   one-cycle claim strobe
//   claim_valid_o  out  one-cycle pulse, claim_id_o valid
//   claim_id_o     out  claimed ID (index+1), 0 when nothing claimable
//   complete_i     in   one-cycle completion strobe
//   lost_clr_i     in   clear all lost counters  (IRQ_GATEWAY_STATS_EN only)
//   lost_cnt_o     out  8 bits per source        (IRQ_GATEWAY_STATS_EN only)
//   complete_id_i  in   ID being completed
// ---------------------------------------------------------------------------
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_SRC + 1)
) (
    input  logic                 core_clk,
    input  logic                 rst_ni,
    input  logic [NUM_SRC-1:0]   irq_src_i,
    input  logic [NUM_SRC-1:0]   edge_mode_i,
    input  logic [NUM_SRC-1:0]   enable_i,
    output logic                 irq_o,
    input  logic                 claim_req_i,
    output logic                 claim_valid_o,
    output logic [ID_W-1:0]      claim_id_o,
    input  logic                 complete_i,
`ifdef IRQ_GATEWAY_STATS_EN
    input  logic                 lost_clr_i,
    output logic [NUM_SRC*8-1:0] lost_cnt_o,
`endif
    input  logic [ID_W-1:0]      complete_id_i
);

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] claim_sel;
    logic [NUM_SRC-1:0] complete_sel;
    logic [31:0]        cand_vec;
    logic [ID_W-1:0]    win_id;
    logic               irq_q;
    logic               irq_d;
    logic               claim_valid_q;
    logic               claim_valid_d;
    logic [ID_W-1:0]    claim_id_q;
    logic [ID_W-1:0]    claim_id_d;

    // Reset asserts asynchronously everywhere at once but is released in
    // step with core_clk, so no flop leaves reset on a metastable edge.
    always_ff @(posedge core_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_gateway_src #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src (
            .core_clk    (core_clk),
            .rst_ni      (rst_n),
            .irq_i       (irq_src_i[i]),
            .edge_mode_i (edge_mode_i[i]),
            .claim_i     (claim_sel[i]),
            .complete_i  (complete_sel[i]),
`ifdef IRQ_GATEWAY_STATS_EN
            .lost_clr_i  (lost_clr_i),
            .lost_cnt_o  (lost_cnt_o[i*8 +: 8]),
`endif
            .pending_o   (pending[i])
        );
    end

    // Claim sees the state as it stands at this edge; a source being
    // completed is CLAIMED, so it can never also be the claim winner.
    always_comb begin
        cand_vec               = '0;
        cand_vec[NUM_SRC-1:0]  = pending & enable_i;
        win_id                 = ID_W'(lowest_id(cand_vec));
        claim_sel              = '0;
        complete_sel           = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_sel[i]    = claim_req_i && (win_id == ID_W'(i + 1));
            complete_sel[i] = complete_i && (complete_id_i == ID_W'(i + 1));
        end
    end

    always_comb begin
        irq_d         = |(pending & enable_i);
        claim_valid_d = claim_req_i;
        claim_id_d    = claim_id_q;
        if (claim_req_i) begin
            claim_id_d = win_id;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q         <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= ID_W'(IRQ_ID_NONE);
        end else begin
            irq_q         <= irq_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
        end
    end

    assign irq_o         = irq_q;
    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;

endmodule

// File: tb/tb_irq_gateway.sv
// ---------------------------------------------------------------------------
// tb_irq_gateway
//   Self-checking bench for irq_gateway. A reference model steps on each
//   rising edge from the request history and the handshake strobes; claim
//   responses it predicts go into a queue that a monitor drains whenever
//   claim_valid_o pulses. irq_o and the held claim_id_o are compared on
//   every falling edge.
// ---------------------------------------------------------------------------
module tb_irq_gateway;

    localparam int NUM_SRC     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = $clog2(NUM_SRC + 1);
    localparam int HD          = SYNC_STAGES + 3;

    localparam int ST_IDLE    = 0;
    localparam int ST_PEND    = 1;
    localparam int ST_CLAIMED = 2;

    logic                 core_clk = 1'b0;
    logic                 rst_ni;
    logic [NUM_SRC-1:0]   irq_src;
    logic [NUM_SRC-1:0]   edge_mode;
    logic [NUM_SRC-1:0]   enable;
    logic                 irq_o;
    logic                 claim_req;
    logic                 claim_valid;
    logic [ID_W-1:0]      claim_id;
    logic                 complete;
    logic [ID_W-1:0]      complete_id;
`ifdef IRQ_GATEWAY_STATS_EN
    logic                 lost_clr;
    logic [NUM_SRC*8-1:0] lost_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    irq_gateway #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES),
        .ID_W        (ID_W)
    ) dut (
        .core_clk      (core_clk),
        .rst_ni        (rst_ni),
        .irq_src_i     (irq_src),
        .edge_mode_i   (edge_mode),
        .enable_i      (enable),
        .irq_o         (irq_o),
        .claim_req_i   (claim_req),
        .claim_valid_o (claim_valid),
        .claim_id_o    (claim_id),
        .complete_i    (complete),
`ifdef IRQ_GATEWAY_STATS_EN
        .lost_clr_i    (lost_clr),
        .lost_cnt_o    (lost_cnt),
`endif
        .complete_id_i (complete_id)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int                 m_state[NUM_SRC];
    bit                 m_seen[NUM_SRC];
    int                 m_lost[NUM_SRC];
    logic [NUM_SRC-1:0] hist[HD];
    bit                 irq_exp;
    int                 exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            m_state[i] = ST_IDLE;
            m_seen[i]  = 1'b0;
            m_lost[i]  = 0;
        end
        for (int j = 0; j < HD; j++) hist[j] = '0;
        irq_exp = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [NUM_SRC-1:0] lvl, prv, trig;
        int  win;
        bit  ev, coal, done;
        // A request value sampled at edge k reaches the state machine at
        // edge k + SYNC_STAGES + 1.
        for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = irq_src;
        lvl = hist[SYNC_STAGES+1];
        prv = hist[SYNC_STAGES+2];
        for (int i = 0; i < NUM_SRC; i++)
            trig[i] = edge_mode[i] ? (lvl[i] & ~prv[i]) : lvl[i];

        irq_exp = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (m_state[i] == ST_PEND && enable[i]) irq_exp = 1'b1;

        win = -1;
        if (claim_req) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (win < 0 && m_state[i] == ST_PEND && enable[i]) win = i;
            exp_q.push_back(win + 1);
        end

        for (int i = 0; i < NUM_SRC; i++) begin
            ev   = edge_mode[i] && trig[i];
            coal = 1'b0;
            done = complete && (int'(complete_id) == i + 1);
            if (m_state[i] == ST_IDLE) begin
                if (trig[i]) m_state[i] = ST_PEND;
            end else if (m_state[i] == ST_PEND) begin
                coal = ev;
                if (win == i) m_state[i] = ST_CLAIMED;
            end else if (done) begin
                coal       = ev && m_seen[i];
                m_state[i] = (edge_mode[i] && (m_seen[i] || trig[i])) ? ST_PEND : ST_IDLE;
                m_seen[i]  = 1'b0;
            end else if (ev) begin
                coal      = m_seen[i];
                m_seen[i] = 1'b1;
            end
`ifdef IRQ_GATEWAY_STATS_EN
            if (lost_clr) m_lost[i] = 0;
            else if (coal && m_lost[i] < 255) m_lost[i]++;
`endif
        end
    endtask

    always @(posedge core_clk or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else         model_step();
    end

    // ---------------- monitor ----------------
    int last_id = 0;

    always @(negedge core_clk) begin
        if (!rst_ni) begin
            last_id = 0;
        end else begin
            check("irq_o", irq_o, irq_exp);
            if (claim_valid) begin
                if (exp_q.size() == 0) begin
                    check("claim_valid_spurious", claim_valid, 0);
                end else begin
                    last_id = exp_q.pop_front();
                    check("claim_id", claim_id, last_id);
                end
            end else begin
                check("claim_id_hold", claim_id, last_id);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic do_claim();
        @(negedge core_clk) claim_req = 1'b1;
        @(negedge core_clk) claim_req = 1'b0;
    endtask

    task automatic do_complete(input int id);
        @(negedge core_clk);
        complete    = 1'b1;
        complete_id = ID_W'(id);
        @(negedge core_clk) complete = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] mask);
        @(negedge core_clk) irq_src = irq_src | mask;
        @(negedge core_clk) irq_src = irq_src & ~mask;
    endtask

    initial begin
        int cl[$];
        int id;
        rst_ni      = 1'b0;
        irq_src     = '0;
        edge_mode   = '0;
        enable      = '1;
        claim_req   = 1'b0;
        complete    = 1'b0;
        complete_id = '0;
`ifdef IRQ_GATEWAY_STATS_EN
        lost_clr    = 1'b0;
`endif
        cyc(3);
        check("rst_irq_o", irq_o, 0);
        check("rst_claim_valid", claim_valid, 0);
        check("rst_claim_id", claim_id, 0);
        rst_ni = 1'b1;
        cyc(5);

        // Level source 3: irq_o rises exactly four cycles after first sample.
        @(negedge core_clk) irq_src[3] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge core_clk);
            check("t1_latency", irq_o, (c == 4) ? 1 : 0);
        end
        do_claim();
        cyc(3);
        check("t1_dropped", irq_o, 0);
        do_complete(4);
        cyc(4);
        check("t1_reassert", irq_o, 1);
        irq_src[3] = 1'b0;
        cyc(5);
        do_claim();
        cyc(2);
        do_complete(4);
        cyc(5);
        check("t1_idle", irq_o, 0);

        // Edge sources 1 and 5 together: claims give 2, 6, 0.
        edge_mode = 8'b0010_0011;
        cyc(2);
        pulse(8'b0010_0010);
        cyc(5);
        do_claim();
        do_claim();
        do_claim();
        cyc(2);
        do_complete(2);
        do_complete(6);
        cyc(3);
        check("t2_quiet", irq_o, 0);

        // Edge source 0: two edges while claimed coalesce into one re-pend.
        pulse(8'b0000_0001);
        cyc(5);
        do_claim();
        cyc(1);
        pulse(8'b0000_0001);
        cyc(1);
        pulse(8'b0000_0001);
        cyc(5);
        do_complete(1);
        cyc(3);
        check("t3_repend", irq_o, 1);
        do_claim();
        cyc(2);
        do_complete(1);
        cyc(2);
        do_claim();
        cyc(3);
        check("t3_quiet", irq_o, 0);
`ifdef IRQ_GATEWAY_STATS_EN
        check("t3_lost0", lost_cnt[7:0], 1);
`endif

        // Disabled pending source stays masked until re-enabled.
        enable[2]  = 1'b0;
        irq_src[2] = 1'b1;
        cyc(6);
        check("t4_masked", irq_o, 0);
        do_claim();
        irq_src[2] = 1'b0;
        cyc(4);
        enable[2] = 1'b1;
        cyc(2);
        check("t4_unmasked", irq_o, 1);
        do_claim();
        cyc(2);
        do_complete(3);
        cyc(3);

        // Stray completes are ignored; claim and complete share a cycle.
        edge_mode = '1;
        cyc(2);
        pulse(8'b0100_0010);
        cyc(5);
        do_complete(7);
        do_complete(0);
        cyc(2);
        check("t5_still_pend", irq_o, 1);
        do_claim();
        cyc(1);
        @(negedge core_clk);
        claim_req   = 1'b1;
        complete    = 1'b1;
        complete_id = ID_W'(2);
        @(negedge core_clk);
        claim_req = 1'b0;
        complete  = 1'b0;
        cyc(2);
        do_complete(7);
        cyc(3);
        check("t5_quiet", irq_o, 0);

        // Asynchronous reset while source 4 is claimed.
        pulse(8'b0001_0000);
        cyc(5);
        do_claim();
        cyc(1);
        pulse(8'b1000_0000);
        cyc(5);
        check("t6_pre_irq", irq_o, 1);
        check("t6_pre_id", claim_id, 5);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_irq", irq_o, 0);
        check("t6_rst_valid", claim_valid, 0);
        check("t6_rst_id", claim_id, 0);
        cyc(3);
        rst_ni = 1'b1;
        cyc(8);
        check("t6_after", irq_o, 0);
        do_claim();
        cyc(3);

        // Randomised traffic against the model.
        edge_mode = NUM_SRC'($urandom);
        cyc(3);
        for (int n = 0; n < 3000; n++) begin
            @(negedge core_clk);
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
            if ($urandom_range(31) == 0) enable = NUM_SRC'($urandom);
            claim_req = ($urandom_range(5) == 0);
            complete  = ($urandom_range(3) == 0);
            cl.delete();
            for (int i = 0; i < NUM_SRC; i++)
                if (m_state[i] == ST_CLAIMED) cl.push_back(i + 1);
            if (cl.size() > 0 && $urandom_range(4) != 0)
                id = cl[$urandom_range(cl.size() - 1)];
            else
                id = $urandom_range(NUM_SRC + 1);
            complete_id = ID_W'(id);
`ifdef IRQ_GATEWAY_STATS_EN
            lost_clr = ($urandom_range(499) == 0);
`endif
        end
        @(negedge core_clk);
        irq_src   = '0;
        claim_req = 1'b0;
        complete  = 1'b0;
`ifdef IRQ_GATEWAY_STATS_EN
        lost_clr  = 1'b0;
`endif
        cyc(10);
        check("drain_queue", exp_q.size(), 0);
`ifdef IRQ_GATEWAY_STATS_EN
        for (int i = 0; i < NUM_SRC; i++)
            check("lost_cnt", lost_cnt[i*8 +: 8], m_lost[i]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_gateway.md
Name: irq_gateway

Overview:
- Receiving end of the core interrupt lines driven by the interrupt source/generator blocks.
- Synchronises up to NUM_SRC asynchronous interrupt requests and converts each to a pending bit (level or rising-edge mode).
- Presents one aggregated interrupt to the core, with a claim/complete handshake that returns the winning source ID.
- Sits between peripheral/testbench interrupt sources and the core's external-interrupt input.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- ID_W, $clog2(NUM_SRC+1), width of source ID; ID 0 means "no interrupt".

Ports:
- core_clk  input  1  core clock; all logic is on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- irq_src_i  input  NUM_SRC  raw interrupt requests, asynchronous to core_clk.
- edge_mode_i  input  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- enable_i  input  NUM_SRC  per-source enable mask.
- irq_o  output  1  registered OR of (pending & enable).
- claim_req_i  input  1  one-cycle claim strobe from the core.
- claim_valid_o  output  1  one-cycle pulse; claim_id_o is valid.
- claim_id_o  output  ID_W  claimed source ID (index+1), or 0 if nothing was claimable.
- complete_i  input  1  one-cycle completion strobe.
- complete_id_i  input  ID_W  ID being completed.

Behaviour:
- Reset (async assert, sync deassert inside the block): irq_o=0, claim_valid_o=0, claim_id_o=0. All synchronisers, edge history and edge_seen bits are 0. Every source is IDLE.
- Synchroniser: SYNC_STAGES flops per source produce sync[i]. A rising edge is sync[i] & ~sync_d[i].
- Per-source FSM, states IDLE, PENDING, CLAIMED:
  - IDLE -> PENDING when the trigger is seen: level mode uses sync[i]=1; edge mode uses a rising edge. This transition happens regardless of enable_i.
  - PENDING -> CLAIMED when a claim selects this source.
  - CLAIMED -> IDLE on complete_i with complete_id_i==i+1. Any other complete is ignored.
  - In CLAIMED, edge mode: a new rising edge sets edge_seen[i]. Further edges coalesce into that one bit. On complete, if edge_seen[i] the source goes to PENDING instead of IDLE and edge_seen[i] clears.
  - After complete, level mode: if sync[i] is still 1, the source re-enters PENDING on the following cycle via IDLE.
  - Edges arriving while PENDING coalesce (no counting).
- Enable: a disabled source keeps its state. It is masked from irq_o and from claim selection. Re-enabling a still-PENDING source raises irq_o again.
- irq_o = register of |(pending & enable_i). Latency from the first cycle sync input samples 1 to irq_o=1 is SYNC_STAGES+2 cycles.
- Claim:
  - On claim_req_i, select the lowest-index source that is PENDING and enabled, as state stands at that edge.
  - Next cycle: claim_valid_o=1, claim_id_o=index+1, and the source's state=CLAIMED. If none is claimable, claim_id_o=0.
  - claim_id_o holds its value until the next claim. claim_valid_o is a one-cycle pulse.
  - irq_o drops one cycle after the claim if no other source is pending.
- Simultaneous events:
  - claim_req_i and complete_i in the same cycle are both applied; they act on disjoint states.
  - A claim_req_i while a claim response is in flight is accepted (back-to-back claims are allowed).
  - A trigger in the same cycle as a complete for the same edge source sets PENDING.
- Reset mid-operation discards all pending and claimed state. No interrupt is regenerated unless the source is still asserted (level mode) or toggles again.

Optional Feature:
- Macro: IRQ_GATEWAY_STATS_EN.
- With the macro defined:
  - Adds output lost_cnt_o [NUM_SRC*8]: per-source saturating 8-bit counters of coalesced edge events (edges while PENDING, or while CLAIMED with edge_seen already 1).
  - Adds input lost_clr_i, which synchronously clears all counters.
  - Counters reset to 0 and saturate at 255.
- Without the macro: no ports and no counters. All other behaviour is identical.

Decomposition:
- Package irq_gateway_pkg holds:
  - typedef enum logic [1:0] irq_state_e {IRQ_IDLE, IRQ_PENDING, IRQ_CLAIMED};
  - localparam IRQ_ID_NONE = 0;
  - a function returning the lowest set bit index + 1 of a vector.
- Sub-module irq_gateway_src holds one source's synchroniser, edge detect, FSM and edge_seen bit. It is instantiated NUM_SRC times with a generate loop. The top level holds the priority select, claim/complete decode and irq_o register.

Test Plan:
- Level source 3 held high, enable=all -> irq_o=1 exactly 4 cycles after the first sampled high. Claim -> claim_id_o=4 and claim_valid_o pulses one cycle later. irq_o falls next cycle. Complete id=4 with source still high -> irq_o re-asserts.
- Edge sources 1 and 5 pulse together -> claims return 2, then 6, then 0. Completing 2 and 6 leaves irq_o=0.
- Edge source 0: pulse, claim (id 1), pulse twice more while CLAIMED, complete id 1 -> source PENDING again, with exactly one more claim returning 1. With the stats macro, lost_cnt for source 0 is 1.
- Source 2 pending with enable[2]=0 -> irq_o=0 and claim returns 0. Set enable[2]=1 -> irq_o=1 and claim returns 3.
- Complete with id 7 while source 6 is not CLAIMED, and complete with id 0 -> no state change. A matching complete in the same cycle as a claim of another source -> both take effect.
- Assert rst_ni=0 asynchronously while source 4 is CLAIMED -> irq_o, claim_valid_o and claim_id_o go 0 immediately. After release with sources low -> no interrupt.
